// File: rtl/vector_lane_sequencer.sv
// rtl/vector_lane_sequencer.sv - serializes a captured 8-lane vector into per-lane beats
// Optional LANE_MASK_EN: skip lanes whose captured mask bit is 0.
module vector_lane_sequencer #(
    parameter int LANE_W    = 8,
    parameter int NUM_LANES = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [LANE_W*NUM_LANES-1:0]   Rv,
    input  logic [NUM_LANES-1:0]          mask,
    output logic                          busy,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANE_W-1:0]             out_data,
    output logic [$clog2(NUM_LANES)-1:0]  out_idx,
    output logic                          out_last,
    output logic                          done
);
    localparam int IDX_W = $clog2(NUM_LANES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                       state, state_n;
    logic [LANE_W*NUM_LANES-1:0]  vec;
    logic [NUM_LANES-1:0]         msk;
    logic [NUM_LANES-1:0]         mask_in;
    logic [IDX_W-1:0]             index, index_n;
    logic [IDX_W-1:0]             first_idx, next_idx;
    logic                         first_found, next_found;
    logic                         capture;

`ifdef LANE_MASK_EN
    assign mask_in = mask;
`else
    // Every lane is enabled; the mask pins exist but carry no meaning here.
    assign mask_in = '1;
    logic unused_mask;
    assign unused_mask = ^mask;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            vec   <= '0;
            msk   <= '0;
            index <= '0;
        end else begin
            state <= state_n;
            index <= index_n;
            if (capture) begin
                vec <= Rv;
                msk <= mask_in;
            end
        end
    end

    // Lowest enabled lane at capture time, and lowest enabled lane above the current index.
    always_comb begin
        first_idx   = '0;
        first_found = 1'b0;
        next_idx    = '0;
        next_found  = 1'b0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (mask_in[k]) begin
                first_idx   = IDX_W'(k);
                first_found = 1'b1;
            end
            if (msk[k] && (k > int'(index))) begin
                next_idx   = IDX_W'(k);
                next_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        index_n = index;
        capture = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    index_n = first_idx;
                    state_n = first_found ? RUN : DONE;
                end
            end
            RUN: begin
                if (out_ready) begin
                    if (next_found) begin
                        index_n = next_idx;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                index_n = '0;
            end
            default: begin
                state_n = IDLE;
                index_n = '0;
            end
        endcase
    end

    assign busy      = (state == RUN) || (state == DONE);
    assign out_valid = (state == RUN);
    assign done      = (state == DONE);
    assign out_data  = out_valid ? vec[int'(index)*LANE_W +: LANE_W] : '0;
    assign out_idx   = out_valid ? index : '0;
    assign out_last  = out_valid && !next_found;

endmodule

// File: doc/vector_lane_sequencer.md
VECTOR_LANE_SEQUENCER -- requirements
Module: vector_lane_sequencer

Interface
REQ-001 Parameter LANE_W, default 8: bits per vector lane.
REQ-002 Parameter NUM_LANES, default 8: lanes per vector (fixed at 8; selector width 3).
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to serialize the vector on Rv; sampled only in IDLE.
REQ-006 Rv  input  64  vector register value, lane k = Rv[8k+7:8k].
REQ-007 mask  input  8  lane enable bits, captured with Rv (used only when LANE_MASK_EN is defined).
REQ-008 busy  output  1  high in RUN and DONE.
REQ-009 out_valid  output  1  lane beat available.
REQ-010 out_ready  input  1  consumer accepts beat.
REQ-011 out_data  output  8  current lane value.
REQ-012 out_idx  output  3  current lane index (selector value).
REQ-013 out_last  output  1  current beat is final lane of this vector.
REQ-014 done  output  1  one-cycle pulse after final beat transfers.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DONE.
REQ-016 IDLE: on start=1, capture Rv and mask into internal registers, load index with first enabled lane, go to RUN next edge.
REQ-017 start SHALL be ignored in RUN and DONE; the captured vector SHALL NOT change until next IDLE capture.
REQ-018 RUN: out_valid=1, out_data = captured lane[index], out_idx = index, out_last=1 iff no enabled lane above index.
REQ-019 Transfer occurs on an edge with out_valid=1 and out_ready=1; without transfer out_data, out_idx, out_last SHALL hold stable.
REQ-020 Transfer with out_last=0: index advances to next enabled lane, still RUN; with out_last=1: go to DONE.
REQ-021 DONE: done=1, out_valid=0 for exactly one cycle, then IDLE.
REQ-022 When out_valid=0, out_data, out_idx and out_last SHALL be 0.
REQ-023 Latency: start at cycle N gives first out_valid at N+1; with out_ready held high, 8 beats at N+1..N+8, done at N+9, IDLE at N+10.
REQ-024 Index SHALL never wrap past lane 7; lane 7 enabled is always last.

Reset
REQ-025 reset=1 SHALL force IDLE on the next edge, dominating start and any transfer in the same cycle.
REQ-026 Reset values: busy=0, out_valid=0, out_data=0, out_idx=0, out_last=0, done=0, captured vector and mask cleared.
REQ-027 Reset mid-RUN SHALL drop the pending beat without asserting done.

Configuration
REQ-028 Macro LANE_MASK_EN: when defined, lanes with captured mask bit 0 SHALL be skipped (no beat); all-zero mask on start SHALL go IDLE -> DONE directly (no beats, done at N+1).
REQ-029 Without LANE_MASK_EN, mask SHALL be ignored and all 8 lanes emitted in order 0..7.

Verification
REQ-030 Rv=64'h0706050403020100, start pulse, out_ready=1 -> out_data 00..07 at N+1..N+8, out_idx 0..7, out_last only at idx 7, done at N+9.
REQ-031 Same vector, out_ready toggling 1,0 -> each beat held stable while ready=0, 8 beats total, done after 16 cycles of RUN.
REQ-032 start held high through operation with Rv changed mid-RUN -> output lanes match vector captured at first start; no restart until IDLE.
REQ-033 reset asserted at 4th beat with out_ready=1 -> next cycle out_valid=0, busy=0, no done pulse; new start then replays from lane 0.
REQ-034 LANE_MASK_EN, mask=8'b1010_0100, Rv=64'h8877665544332211 -> beats 33 (idx 2), 66 (idx 5), 88 (idx 7, last), then done.
REQ-035 LANE_MASK_EN, mask=8'h00 -> no out_valid, done at N+1, IDLE at N+2.
